// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Optional BTB_STATS_EN adds HitCount/AllocCount statistics outputs.
module branch_target_buffer #(
    parameter int         INDEX_BITS = 4,
    parameter logic [1:0] CTR_INIT   = 2'b10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PCIn,
    output logic [31:0] PredNextPC,
    output logic        PredTaken,
    output logic        PredHit,
    input  logic        UpdValid,
    input  logic [31:0] UpdPC,
    input  logic        UpdTaken,
    input  logic [31:0] UpdTarget
`ifdef BTB_STATS_EN
    ,
    output logic [31:0] HitCount,
    output logic [31:0] AllocCount
`endif
);

    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int TAG_BITS = 32 - INDEX_BITS - 2;

    logic                  valid_q  [ENTRIES];
    logic                  valid_d  [ENTRIES];
    logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
    logic [TAG_BITS-1:0]   tag_d    [ENTRIES];
    logic [31:0]           target_q [ENTRIES];
    logic [31:0]           target_d [ENTRIES];
    logic [1:0]            ctr_q    [ENTRIES];
    logic [1:0]            ctr_d    [ENTRIES];

    logic [INDEX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0]   lk_tag;
    logic [INDEX_BITS-1:0] upd_idx;
    logic [TAG_BITS-1:0]   upd_tag;
    logic                  upd_hit;
    logic                  alloc;
    logic                  unused_pc_lsbs;

    assign lk_idx         = PCIn[INDEX_BITS+1:2];
    assign lk_tag         = PCIn[31:INDEX_BITS+2];
    assign upd_idx        = UpdPC[INDEX_BITS+1:2];
    assign upd_tag        = UpdPC[31:INDEX_BITS+2];
    assign unused_pc_lsbs = ^{PCIn[1:0], UpdPC[1:0]};

    // Lookup sees pre-edge table contents; Reset also forces a miss.
    always_comb begin
        PredHit    = Reset && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        PredTaken  = PredHit && ctr_q[lk_idx][1];
        PredNextPC = PredTaken ? target_q[lk_idx] : PCIn + 32'd4;
    end

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        alloc    = 1'b0;
        upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        if (UpdValid) begin
            if (upd_hit) begin
                if (UpdTaken) begin
                    target_d[upd_idx] = UpdTarget;
                    if (ctr_q[upd_idx] != 2'b11)
                        ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
                end else if (ctr_q[upd_idx] != 2'b00) begin
                    ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
                end
            end else if (UpdTaken) begin
                alloc             = 1'b1;
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = UpdTarget;
                ctr_d[upd_idx]    = CTR_INIT;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] alloc_count_q, alloc_count_d;

    always_comb begin
        hit_count_d   = hit_count_q + {31'b0, PredHit};
        alloc_count_d = alloc_count_q + {31'b0, alloc};
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            hit_count_q   <= '0;
            alloc_count_q <= '0;
        end else begin
            hit_count_q   <= hit_count_d;
            alloc_count_q <= alloc_count_d;
        end
    end

    assign HitCount   = hit_count_q;
    assign AllocCount = alloc_count_q;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed scenarios plus random
// traffic compared against an array-based table model.
module tb_branch_target_buffer;

    localparam int N_ENT = 16;

    logic        Clk;
    logic        Reset;
    logic [31:0] PCIn;
    logic [31:0] PredNextPC;
    logic        PredTaken;
    logic        PredHit;
    logic        UpdValid;
    logic [31:0] UpdPC;
    logic        UpdTaken;
    logic [31:0] UpdTarget;
`ifdef BTB_STATS_EN
    logic [31:0] HitCount;
    logic [31:0] AllocCount;
`endif

    branch_target_buffer dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .PCIn       (PCIn),
        .PredNextPC (PredNextPC),
        .PredTaken  (PredTaken),
        .PredHit    (PredHit),
        .UpdValid   (UpdValid),
        .UpdPC      (UpdPC),
        .UpdTaken   (UpdTaken),
        .UpdTarget  (UpdTarget)
`ifdef BTB_STATS_EN
        ,
        .HitCount   (HitCount),
        .AllocCount (AllocCount)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Reference table: one record per index, counter as a plain integer 0..3.
    bit          m_valid [N_ENT];
    int unsigned m_tag   [N_ENT];
    int unsigned m_tgt   [N_ENT];
    int          m_ctr   [N_ENT];
    int unsigned m_hits;
    int unsigned m_allocs;

    function automatic int m_idx(input int unsigned pc);
        return int'((pc >> 2) % N_ENT);
    endfunction

    function automatic bit m_hit(input int unsigned pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == (pc >> 6));
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N_ENT; i++) begin
            m_valid[i] = 0;
            m_ctr[i]   = 1;
        end
        m_hits   = 0;
        m_allocs = 0;
    endtask

    task automatic m_update(input int unsigned pc, input bit taken, input int unsigned tgt);
        int i;
        i = m_idx(pc);
        if (m_hit(pc)) begin
            if (taken) begin
                m_tgt[i] = tgt;
                m_ctr[i] = (m_ctr[i] >= 3) ? 3 : m_ctr[i] + 1;
            end else begin
                m_ctr[i] = (m_ctr[i] <= 0) ? 0 : m_ctr[i] - 1;
            end
        end else if (taken) begin
            m_valid[i] = 1;
            m_tag[i]   = pc >> 6;
            m_tgt[i]   = tgt;
            m_ctr[i]   = 2;
            m_allocs++;
        end
    endtask

    task automatic check_lookup(input string tag);
        int unsigned pc;
        bit          h, t;
        pc = PCIn;
        h  = Reset && m_hit(pc);
        t  = h && (m_ctr[m_idx(pc)] >= 2);
        chk({tag, "_hit"}, {31'b0, PredHit}, {31'b0, h});
        chk({tag, "_taken"}, {31'b0, PredTaken}, {31'b0, t});
        chk({tag, "_next"}, PredNextPC, t ? m_tgt[m_idx(pc)] : pc + 32'd4);
    endtask

    task automatic check_stats(input string tag);
`ifdef BTB_STATS_EN
        chk({tag, "_hitcnt"}, HitCount, m_hits);
        chk({tag, "_alloccnt"}, AllocCount, m_allocs);
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    // One clock: drive at negedge, check lookup, let the edge apply the update.
    task automatic step(input string tag, input logic [31:0] pc, input logic uv,
                        input logic [31:0] upc, input logic ut, input logic [31:0] utgt);
        bit pre_hit;
        PCIn = pc; UpdValid = uv; UpdPC = upc; UpdTaken = ut; UpdTarget = utgt;
        #1;
        check_lookup(tag);
        pre_hit = Reset && m_hit(pc);
        @(posedge Clk);
        if (Reset) begin
            if (pre_hit) m_hits++;
            if (uv) m_update(upc, ut, utgt);
        end
        @(negedge Clk);
        check_stats(tag);
    endtask

    task automatic look(input string tag, input logic [31:0] pc);
        step(tag, pc, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic pulse_reset(input logic [31:0] pc, input logic [31:0] upc, input logic [31:0] utgt);
        PCIn = pc; UpdValid = 1'b1; UpdPC = upc; UpdTaken = 1'b1; UpdTarget = utgt;
        #1;
        check_lookup("prerst");
        Reset = 1'b0;
        #1;
        chk("rst_async_hit", {31'b0, PredHit}, 32'd0);
        chk("rst_async_taken", {31'b0, PredTaken}, 32'd0);
        chk("rst_async_next", PredNextPC, pc + 32'd4);
        @(posedge Clk);
        m_reset();
        @(negedge Clk);
        Reset = 1'b1;
        UpdValid = 1'b0;
        #1;
        check_stats("postrst");
        @(negedge Clk);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        if ($urandom_range(0, 19) == 0) return 32'hFFFF_FFFC;
        p = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
        return p;
    endfunction

    initial begin
        Reset = 1'b0; PCIn = 32'h40; UpdValid = 1'b0; UpdPC = '0; UpdTaken = 1'b0; UpdTarget = '0;
        m_reset();
        @(negedge Clk);
        #1;
        chk("reset_hit", {31'b0, PredHit}, 32'd0);
        chk("reset_next", PredNextPC, 32'h44);
        check_stats("reset");
        @(negedge Clk);
        Reset = 1'b1;

        look("rel", 32'h40);
        step("alloc", 32'h40, 1'b1, 32'h40, 1'b1, 32'h100);
        look("after_alloc", 32'h40);
        chk("alloc_target", PredNextPC, 32'h100);
        step("nt1", 32'h40, 1'b1, 32'h40, 1'b0, 32'h0);
        step("nt2", 32'h40, 1'b1, 32'h40, 1'b0, 32'h0);
        look("ctr00", 32'h40);
        chk("ctr00_next", PredNextPC, 32'h44);
        for (int k = 0; k < 4; k++) step("tk", 32'h40, 1'b1, 32'h40, 1'b1, 32'h100);
        look("ctr11", 32'h40);
        step("nt_sat", 32'h40, 1'b1, 32'h40, 1'b0, 32'h0);
        look("ctr10", 32'h40);
        step("miss_nt", 32'h80, 1'b1, 32'h80, 1'b0, 32'h500);
        look("miss_nt_chk", 32'h80);
        step("alias_a", 32'h40, 1'b1, 32'h440, 1'b1, 32'h200);
        look("alias_old", 32'h40);
        look("alias_new", 32'h440);
        chk("alias_target", PredNextPC, 32'h200);
        look("wrap", 32'hFFFF_FFFC);
        chk("wrap_next", PredNextPC, 32'h0);
        step("same_cyc", 32'h440, 1'b1, 32'h440, 1'b1, 32'h300);
        look("same_next", 32'h440);
        step("alloc2", 32'h10, 1'b1, 32'h14, 1'b1, 32'h800);
        pulse_reset(32'h440, 32'h80, 32'h900);
        look("post_rst_a", 32'h440);
        look("post_rst_b", 32'h80);

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 79) == 0)
                pulse_reset(rand_pc(), rand_pc(), $urandom());
            else
                step("rnd", rand_pc(), 1'($urandom_range(0, 1)), rand_pc(),
                     1'($urandom_range(0, 3) != 0), $urandom());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
Next-PC predictor that sits directly upstream of the program counter register and drives its Address input each cycle. It is a direct-mapped table of branch targets with 2-bit saturating direction counters. Lookup is combinational on the current PC; updates come from branch resolution in EX and are written at posedge Clk.

Parameters:
INDEX_BITS, 4, log2 of entry count (ENTRIES = 2**INDEX_BITS = 16 by default)
CTR_INIT, 2'b10, counter value written on allocation (weakly taken)

Ports:
Clk  input  1  system clock, all state updates on posedge
Reset  input  1  asynchronous, active-low (0 = reset asserted); clears table state immediately
PCIn  input  32  current PC (PC register output)
PredNextPC  output  32  predicted next PC, drives PC register Address input
PredTaken  output  1  prediction is taken (redirect to stored target)
PredHit  output  1  valid tag match at PCIn's index
UpdValid  input  1  resolved branch/jump update strobe from EX
UpdPC  input  32  PC of the resolved instruction
UpdTaken  input  1  actual outcome
UpdTarget  input  32  actual target address

Behaviour:
- Index = PC[INDEX_BITS+1:2]; tag = PC[31:INDEX_BITS+2]; PC[1:0] ignored for both lookup and update.
- Entry = {valid, tag, target[31:0], ctr[1:0]}.
- Lookup (combinational): PredHit = valid & tag match; PredTaken = PredHit & ctr[1]; PredNextPC = PredTaken ? target : PCIn + 32'd4.
- PCIn + 4 wraps modulo 2^32: 0xFFFFFFFC -> 0x00000000.
- Update at posedge Clk when UpdValid = 1 and Reset = 1:
  - Hit on UpdPC, taken: ctr saturating increment (max 2'b11); target <= UpdTarget.
  - Hit, not taken: ctr saturating decrement (min 2'b00); target unchanged; entry stays valid.
  - Miss, taken: allocate, overwriting any entry at that index: valid <= 1, tag <= UpdPC tag, target <= UpdTarget, ctr <= CTR_INIT.
  - Miss, not taken: no change.
- UpdValid = 0: table holds.
- A PC-register stall does not affect this block; lookup simply re-evaluates on the held PCIn.
- Same-cycle lookup and update to the same index: lookup returns pre-edge contents; the new contents are visible from the next cycle.
- Reset asserted (Reset = 0), including mid-operation:
  - All valid bits cleared and all ctr = 2'b01 asynchronously; targets and tags are don't-care.
  - While in reset: PredHit = 0, PredTaken = 0, PredNextPC = PCIn + 4.
  - Updates are ignored while Reset = 0.
- Aliasing: different PCs with the same index and different tags are a miss for each other. An allocation from one evicts the other.

Optional Feature:
BTB_STATS_EN
- Defined: adds outputs HitCount[31:0] and AllocCount[31:0], both cleared by Reset.
  - HitCount increments at each posedge where PredHit = 1.
  - AllocCount increments on each allocation.
  - Both wrap at 2^32.
- Not defined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset = 0, PCIn = 0x00000040 -> PredHit = 0, PredTaken = 0, PredNextPC = 0x00000044; release Reset, same PCIn -> outputs unchanged.
- Update UpdPC = 0x00000040, UpdTaken = 1, UpdTarget = 0x00000100; next cycle PCIn = 0x00000040 -> PredHit = 1, ctr = 2'b10, PredTaken = 1, PredNextPC = 0x00000100.
- Same PC, two not-taken updates -> ctr 10 -> 01 -> 00, PredTaken = 0, PredNextPC = 0x00000044, PredHit = 1. Then three taken updates -> ctr reaches 11 and saturates; a fourth taken update leaves ctr = 11.
- Miss with UpdTaken = 0 at UpdPC = 0x00000080 -> no allocation; PCIn = 0x00000080 gives PredHit = 0. Aliasing: allocate 0x00000040 -> 0x100, then allocate 0x00000440 -> 0x200 (same index) -> lookup of 0x00000040 misses, lookup of 0x00000440 returns 0x200.
- Wrap and same-cycle access:
  - PCIn = 0xFFFFFFFC with a miss -> PredNextPC = 0x00000000.
  - Update and lookup at the same index in one cycle -> old value that cycle, new value the next.
- Reset pulsed low mid-stream after several allocations -> PredHit = 0 immediately, before the next clock edge; an update pending during reset is not written. With BTB_STATS_EN defined, HitCount and AllocCount = 0 after reset.
